// File: rtl/writeback_stage_pkg.sv
// Shared core package for the writeback stage: datapath sizes and the
// writeback mux and load-width encodings.
package writeback_stage_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_PC4  = 2'd2,
        SEL_IMM  = 2'd3
    } rd_data_sel_e;

    // Encoding 2'd3 is not named; it is treated as a full word, like W_WORD.
    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } data_width_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEMEX/WB pipeline register contents and the data-memory read return
// as seen by the writeback stage, plus the stall that goes back upstream.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic                    invalid_WB;
    logic [XLEN-1:0]         pc4_WB;
    logic [REG_AW-1:0]       rd_WB;
    logic [XLEN-1:0]         alu_result_WB;
    logic                    regfile_we_WB;
    rd_data_sel_e            rd_data_sel_WB;
    logic                    lsu_sign_extend_WB;
    logic [1:0]              data_width_WB;
    logic [XLEN-1:0]         immediate_WB;
    logic [XLEN-1:0]         dmem_rdata;
    logic                    dmem_rvalid;
    logic                    stall_WB;

    modport master (
        output invalid_WB, pc4_WB, rd_WB, alu_result_WB, regfile_we_WB,
               rd_data_sel_WB, lsu_sign_extend_WB, data_width_WB, immediate_WB,
               dmem_rdata, dmem_rvalid,
        input  stall_WB
    );

    modport slave (
        input  invalid_WB, pc4_WB, rd_WB, alu_result_WB, regfile_we_WB,
               rd_data_sel_WB, lsu_sign_extend_WB, data_width_WB, immediate_WB,
               dmem_rdata, dmem_rvalid,
        output stall_WB
    );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Combinational load formatter: picks the byte/halfword lane addressed by
// the low address bits and sign- or zero-extends it to XLEN.
module load_formatter
    import writeback_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [1:0]      width,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halfword selection uses only offset[1]; a misaligned bit 0 is ignored.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        data      = '0;
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            W_BYTE:  data = {{(XLEN-8){sign_ext & byte_lane[7]}}, byte_lane};
            W_HALF:  data = {{(XLEN-16){sign_ext & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage with the RV32E register file, load stall and read bypass.
// Define WB_RETIRE_COUNTER_EN to add the retired_count port and its counter.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage_if.slave  wb,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]       retired_count
`endif
);

    logic            valid;
    logic            is_load;
    logic            commit;
    logic            write;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] regs [NUM_REGS];

    load_formatter u_load_formatter (
        .rdata    (wb.dmem_rdata),
        .offset   (wb.alu_result_WB[1:0]),
        .width    (wb.data_width_WB),
        .sign_ext (wb.lsu_sign_extend_WB),
        .data     (load_data)
    );

    // A stall depends only on current inputs, so a bubble never stalls, even in reset.
    assign valid       = !wb.invalid_WB;
    assign is_load     = valid && (wb.rd_data_sel_WB == SEL_LOAD);
    assign wb.stall_WB = is_load && !wb.dmem_rvalid;
    assign commit      = valid && !wb.stall_WB;
    assign write       = commit && wb.regfile_we_WB && (wb.rd_WB != '0);

    always_comb begin
        wdata = '0;
        case (wb.rd_data_sel_WB)
            SEL_ALU:  wdata = wb.alu_result_WB;
            SEL_LOAD: wdata = load_data;
            SEL_PC4:  wdata = wb.pc4_WB;
            default:  wdata = wb.immediate_WB;
        endcase
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[wb.rd_WB] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (write && (rs1_addr == wb.rd_WB)) ? wdata : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (write && (rs2_addr == wb.rd_WB)) ? wdata : regs[rs2_addr];

`ifdef WB_RETIRE_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (commit) begin
            retired_count <= retired_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vectors against a
// behavioural register-file model, plus hand-computed literal expectations.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  rs1_addr = 4'd0;
    logic [3:0]  rs2_addr = 4'd0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] retired_count;
    logic [63:0] count_before;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_regs [16];
    logic [63:0] exp_count = 64'd0;

    writeback_stage_if wbif ();

    writeback_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb       (wbif),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model of what the stage must do with the current inputs
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] width, input logic sext);
        logic [31:0] v;
        if (width >= 2'd2) return word;
        if (width == 2'd0) begin
            v = (word >> (8 * addr[1:0])) & 32'h0000_00FF;
            if (sext && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (word >> (16 * addr[1])) & 32'h0000_FFFF;
            if (sext && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic model_commit();
        if (wbif.invalid_WB) return 1'b0;
        if (wbif.rd_data_sel_WB == SEL_LOAD && !wbif.dmem_rvalid) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_write();
        return model_commit() && wbif.regfile_we_WB && (wbif.rd_WB != 4'd0);
    endfunction

    function automatic logic [31:0] model_wdata();
        if (wbif.rd_data_sel_WB == SEL_ALU)  return wbif.alu_result_WB;
        if (wbif.rd_data_sel_WB == SEL_LOAD)
            return model_load(wbif.dmem_rdata, wbif.alu_result_WB, wbif.data_width_WB,
                              wbif.lsu_sign_extend_WB);
        if (wbif.rd_data_sel_WB == SEL_PC4)  return wbif.pc4_WB;
        return wbif.immediate_WB;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        if (addr == 4'd0) return 32'd0;
        if (model_write() && addr == wbif.rd_WB) return model_wdata();
        return exp_regs[addr];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) exp_regs[i] <= 32'd0;
            exp_count <= 64'd0;
        end else begin
            if (model_commit()) exp_count <= exp_count + 64'd1;
            if (model_write()) exp_regs[wbif.rd_WB] <= model_wdata();
        end
    end

    always @(negedge clk) begin
        checkOutput("stall_WB", {63'd0, wbif.stall_WB},
                    {63'd0, !wbif.invalid_WB && wbif.rd_data_sel_WB == SEL_LOAD && !wbif.dmem_rvalid});
        checkOutput("rs1_data", {32'd0, rs1_data}, {32'd0, model_read(rs1_addr)});
        checkOutput("rs2_data", {32'd0, rs2_data}, {32'd0, model_read(rs2_addr)});
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("retired_count", retired_count, exp_count);
`endif
    end

    task automatic applyStimulus(input logic inv, input rd_data_sel_e sel, input logic [3:0] rd,
                                 input logic we, input logic [31:0] alu, input logic [1:0] width,
                                 input logic sext, input logic [31:0] rdata, input logic rvalid);
        wbif.invalid_WB         = inv;
        wbif.rd_data_sel_WB     = sel;
        wbif.rd_WB              = rd;
        wbif.regfile_we_WB      = we;
        wbif.alu_result_WB      = alu;
        wbif.data_width_WB      = width;
        wbif.lsu_sign_extend_WB = sext;
        wbif.dmem_rdata         = rdata;
        wbif.dmem_rvalid        = rvalid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wbif.pc4_WB       = 32'h0000_1004;
        wbif.immediate_WB = 32'hFFFF_F800;
        applyStimulus(1'b1, SEL_LOAD, 4'd3, 1'b1, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        #1 rst_n = 1'b0;
        #11;
        rs1_addr = 4'd3;
        #1;
        checkOutput("reset_stall_bubble", {63'd0, wbif.stall_WB}, 64'd0);
        checkOutput("reset_read_x3", {32'd0, rs1_data}, 64'd0);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("reset_count", retired_count, 64'd0);
`endif
        rst_n = 1'b1;
        step();

        // ALU write with same-cycle bypass, then read back from storage
        applyStimulus(1'b0, SEL_ALU, 4'd5, 1'b1, 32'h1234_5678, 2'd2, 1'b0, 32'd0, 1'b0);
        rs1_addr = 4'd5;
        #2 checkOutput("alu_bypass_x5", {32'd0, rs1_data}, 64'h1234_5678);
        step();
        applyStimulus(1'b1, SEL_ALU, 4'd0, 1'b0, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        #2 checkOutput("alu_stored_x5", {32'd0, rs1_data}, 64'h1234_5678);

        // Signed byte load from lane 2
        applyStimulus(1'b0, SEL_LOAD, 4'd6, 1'b1, 32'h0000_1002, 2'd0, 1'b1, 32'h0080_0000, 1'b1);
        rs2_addr = 4'd6;
        #2 checkOutput("sbyte_bypass_x6", {32'd0, rs2_data}, 64'hFFFF_FF80);
        step();

        // Unsigned half load at offset 3 (bit 0 ignored -> upper half)
        applyStimulus(1'b0, SEL_LOAD, 4'd7, 1'b1, 32'h0000_2003, 2'd1, 1'b0, 32'hBEEF_0000, 1'b1);
        rs1_addr = 4'd7;
        #2 checkOutput("uhalf_bypass_x7", {32'd0, rs1_data}, 64'h0000_BEEF);
        step();
        #2 checkOutput("sbyte_stored_x6", {32'd0, rs2_data}, 64'hFFFF_FF80);

        // Load that waits three cycles for data
`ifdef WB_RETIRE_COUNTER_EN
        count_before = retired_count;
`endif
        applyStimulus(1'b0, SEL_LOAD, 4'd8, 1'b1, 32'h0000_3000, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
        rs1_addr = 4'd8;
        for (int i = 0; i < 3; i++) begin
            #2 checkOutput("load_stall_high", {63'd0, wbif.stall_WB}, 64'd1);
            step();
        end
        wbif.dmem_rvalid = 1'b1;
        #2 checkOutput("load_stall_low", {63'd0, wbif.stall_WB}, 64'd0);
        checkOutput("load_bypass_x8", {32'd0, rs1_data}, 64'hCAFE_F00D);
        step();
        applyStimulus(1'b1, SEL_ALU, 4'd0, 1'b0, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        #2 checkOutput("load_stored_x8", {32'd0, rs1_data}, 64'hCAFE_F00D);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("load_one_count", retired_count - count_before, 64'd1);
`endif
        step();

        // Bubble must not write x7; a bubble with a load select never stalls
        applyStimulus(1'b1, SEL_ALU, 4'd7, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'd0, 1'b0);
        rs1_addr = 4'd7;
        step();
        applyStimulus(1'b1, SEL_LOAD, 4'd7, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'd0, 1'b0);
        #2 checkOutput("bubble_no_write_x7", {32'd0, rs1_data}, 64'h0000_BEEF);
        checkOutput("bubble_no_stall", {63'd0, wbif.stall_WB}, 64'd0);
        step();

        // Write to x0 is dropped, even through the bypass
        applyStimulus(1'b0, SEL_ALU, 4'd0, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'd0, 1'b1);
        rs1_addr = 4'd0;
        #2 checkOutput("x0_bypass_zero", {32'd0, rs1_data}, 64'd0);
        step();
        #2 checkOutput("x0_stored_zero", {32'd0, rs1_data}, 64'd0);

        // PC+4 and immediate selects; signed half; unsigned byte lane 3; we=0
        applyStimulus(1'b0, SEL_PC4, 4'd9, 1'b1, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        rs1_addr = 4'd9;
        #2 checkOutput("pc4_bypass_x9", {32'd0, rs1_data}, 64'h0000_1004);
        step();
        applyStimulus(1'b0, SEL_IMM, 4'd10, 1'b1, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        rs2_addr = 4'd10;
        #2 checkOutput("imm_bypass_x10", {32'd0, rs2_data}, 64'hFFFF_F800);
        step();
        applyStimulus(1'b0, SEL_LOAD, 4'd12, 1'b1, 32'h0000_0000, 2'd1, 1'b1, 32'h1234_8001, 1'b1);
        rs1_addr = 4'd12;
        #2 checkOutput("shalf_bypass_x12", {32'd0, rs1_data}, 64'hFFFF_8001);
        step();
        applyStimulus(1'b0, SEL_LOAD, 4'd13, 1'b1, 32'h0000_0003, 2'd0, 1'b0, 32'hA500_0000, 1'b1);
        rs2_addr = 4'd13;
        #2 checkOutput("ubyte_bypass_x13", {32'd0, rs2_data}, 64'h0000_00A5);
        step();
        applyStimulus(1'b0, SEL_ALU, 4'd9, 1'b0, 32'h5555_5555, 2'd3, 1'b0, 32'd0, 1'b0);
        rs1_addr = 4'd9;
        step();
        #2 checkOutput("we0_keeps_x9", {32'd0, rs1_data}, 64'h0000_1004);

        // Fill every register; the compare process checks bypass and storage
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, SEL_ALU, 4'(i), 1'b1, (32'h0101_0101 * i) ^ 32'h8000_0000,
                          2'd2, 1'b0, 32'd0, 1'b1);
            rs1_addr = 4'(i);
            rs2_addr = 4'(i - 1);
            step();
        end

        // Async reset in the middle of a stall
        applyStimulus(1'b0, SEL_LOAD, 4'd11, 1'b1, 32'h0000_4000, 2'd2, 1'b0, 32'h7777_7777, 1'b0);
        rs1_addr = 4'd5;
        rs2_addr = 4'd15;
        step();
        #2 checkOutput("pre_reset_x5", {32'd0, rs1_data}, {32'd0, (32'h0101_0101 * 5) ^ 32'h8000_0000});
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_x5", {32'd0, rs1_data}, 64'd0);
        checkOutput("async_reset_x15", {32'd0, rs2_data}, 64'd0);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("async_reset_count", retired_count, 64'd0);
`endif
        wbif.dmem_rvalid = 1'b1;
        step();
        applyStimulus(1'b1, SEL_ALU, 4'd0, 1'b0, 32'd0, 2'd2, 1'b0, 32'd0, 1'b0);
        rs1_addr = 4'd11;
        #2 rst_n = 1'b1;
        #1 checkOutput("reset_no_write_x11", {32'd0, rs1_data}, 64'd0);
`ifdef WB_RETIRE_COUNTER_EN
        checkOutput("reset_no_count", retired_count, 64'd0);
`endif
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
